// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store initiator for one port of a word-wide memory without byte enables.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests answer with resp_error instead of aligning.
module load_store_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_error,
    output logic        memory_write_enable,
    output logic [31:0] memory_access_address,
    output logic [31:0] memory_write_data,
    input  logic [31:0] memory_read_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        misalign;
    logic [1:0]  off_eff;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_address[31:ADDR_WIDTH+2];

    // Offsets below natural alignment are dropped; with the trap on they never reach memory anyway.
    assign off_eff = req_size[1]        ? 2'b00 :
                     (req_size == 2'b01) ? {req_address[1], 1'b0} : req_address[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_address[0]) ||
                      (req_size[1] && (req_address[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00)
            r[{off, 3'b000} +: 8] = d[7:0];
        else if (off[1])
            r[31:16] = d;
        else
            r[15:0] = d;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            req_ready             <= 1'b1;
            resp_valid            <= 1'b0;
            resp_read_data        <= 32'd0;
            resp_error            <= 1'b0;
            memory_write_enable   <= 1'b0;
            memory_access_address <= 32'd0;
            memory_write_data     <= 32'd0;
            size_q                <= 2'b00;
            uns_q                 <= 1'b0;
            write_q               <= 1'b0;
            off_q                 <= 2'b00;
            wdata_q               <= 16'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    size_q    <= req_size;
                    uns_q     <= req_unsigned;
                    write_q   <= req_write;
                    off_q     <= off_eff;
                    wdata_q   <= req_write_data[15:0];
                    if (misalign) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        state      <= RESP;
                    end else begin
                        memory_access_address <= {{(32-ADDR_WIDTH){1'b0}}, req_address[ADDR_WIDTH+1:2]};
                        memory_write_enable   <= req_write & req_size[1];
                        if (req_write && req_size[1])
                            memory_write_data <= req_write_data;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    memory_write_enable <= 1'b0;
                    if (write_q && size_q[1]) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (write_q) begin
                        memory_write_data   <= merge(memory_read_data, size_q, off_q, wdata_q);
                        memory_write_enable <= 1'b1;
                        state               <= WRITE;
                    end else begin
                        resp_read_data <= extract(memory_read_data, size_q, off_q, uns_q);
                        resp_valid     <= 1'b1;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    memory_write_enable <= 1'b0;
                    resp_valid          <= 1'b1;
                    state               <= RESP;
                end
                RESP: begin
                    resp_valid     <= 1'b0;
                    resp_read_data <= 32'd0;
                    resp_error     <= 1'b0;
                    req_ready      <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, random traffic against a byte-level reference.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_write_data;
    logic        resp_valid, resp_error;
    logic [31:0] resp_read_data;
    logic        memory_write_enable;
    logic [31:0] memory_access_address, memory_write_data, memory_read_data;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int cyc = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    load_store_unit #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_read_data(resp_read_data), .resp_error(resp_error),
        .memory_write_enable(memory_write_enable), .memory_access_address(memory_access_address),
        .memory_write_data(memory_write_data), .memory_read_data(memory_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory port with write-before-read.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memory_write_enable) begin
            mem[memory_access_address[11:0]] <= memory_write_data;
            we_count <= we_count + 1;
        end
        memory_read_data <= memory_write_enable ? memory_write_data : mem[memory_access_address[11:0]];
    end

    logic [31:0] ref_mem [0:4095];

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
        return TRAP && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        int off;
        logic [31:0] v;
        off = int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (8 * (off & 2))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] d);
        int sh;
        logic [31:0] mask;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else if (sz == 2'd1) begin
            sh = 8 * (int'(a[1:0]) & 2);
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (word & ~mask) | ((d << sh) & mask);
    endfunction

    // Drives one request; returns response data, latency in cycles after accept (-1 on timeout),
    // memory writes seen and the accept cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat, output int nwr, output int acc);
        int t, wr0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_write_data = d;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        wr0 = we_count;
        @(posedge clk);
        acc = cyc;
        #1;
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~u;
        req_address = $urandom; req_write_data = $urandom;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (lat >= 20) lat = -1;
        rd = resp_read_data; er = resp_error; nwr = we_count - wr0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_address = 32'd0; req_write_data = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({resp_valid, resp_error, memory_write_enable} !== 3'b000 || resp_read_data !== 32'd0 ||
            memory_access_address !== 32'd0 || memory_write_data !== 32'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got rv=%b re=%b we=%b rd=%h ma=%h wd=%h rr=%b want zeros and rr=1",
                     resp_valid, resp_error, memory_write_enable, resp_read_data,
                     memory_access_address, memory_write_data, req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic er; int lat, nwr, acc;
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, nwr, acc);
        checks++;
        if (lat !== 1 || er !== 1'b0 || nwr !== 1 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store lat=%0d er=%b nwr=%0d mem4=%h want 1 0 1 deadbeef", lat, er, nwr, mem[4]);
        end
        ref_mem[4] = 32'hDEADBEEF;
        do_req(1, 2'd2, 0, 32'h10, 32'h80FF1234, rd, er, lat, nwr, acc);
        ref_mem[4] = 32'h80FF1234;
        do_req(0, 2'd0, 0, 32'h13, 32'h0, rd, er, lat, nwr, acc);
        checks++;
        if (rd !== 32'hFFFFFF80 || lat !== 2) begin
            errors++; $display("FAIL byte_load_signed rd=%h lat=%0d want ffffff80 2", rd, lat);
        end
        do_req(0, 2'd0, 1, 32'h13, 32'h0, rd, er, lat, nwr, acc);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++; $display("FAIL byte_load_unsigned rd=%h want 00000080", rd);
        end
        do_req(1, 2'd2, 0, 32'h10, 32'h11223344, rd, er, lat, nwr, acc);
        do_req(1, 2'd1, 0, 32'h12, 32'hAAAA5A5A, rd, er, lat, nwr, acc);
        checks++;
        if (lat !== 3 || nwr !== 1 || mem[4] !== 32'h5A5A3344 || rd !== 32'd0) begin
            errors++;
            $display("FAIL half_store lat=%0d nwr=%0d mem4=%h rd=%h want 3 1 5a5a3344 0", lat, nwr, mem[4], rd);
        end
        ref_mem[4] = 32'h5A5A3344;
        do_req(0, 2'd2, 0, 32'h4010, 32'h0, rd, er, lat, nwr, acc);
        checks++;
        if (rd !== 32'h5A5A3344 || memory_access_address !== 32'd4) begin
            errors++;
            $display("FAIL alias_load rd=%h ma=%h want 5a5a3344 4", rd, memory_access_address);
        end
        do_req(0, 2'd1, 1, 32'h11, 32'h0, rd, er, lat, nwr, acc);
        checks++;
        if (TRAP && (lat !== 0 || er !== 1'b1 || rd !== 32'd0 || nwr !== 0)) begin
            errors++; $display("FAIL misalign_trap lat=%0d er=%b rd=%h nwr=%0d want 0 1 0 0", lat, er, rd, nwr);
        end else if (!TRAP && (lat !== 2 || er !== 1'b0 || rd !== 32'h00003344)) begin
            errors++; $display("FAIL misalign_align lat=%0d er=%b rd=%h want 2 0 00003344", lat, er, rd);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_error !== 1'b0) begin
            errors++; $display("FAIL resp_one_cycle rv=%b rr=%b re=%b want 0 1 0", resp_valid, req_ready, resp_error);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, nwr, a0, a1, a2, a3;
        do_req(1, 2'd2, 0, 32'h20, 32'h0BADF00D, rd, er, lat, nwr, a0);
        do_req(1, 2'd3, 0, 32'h24, 32'h12345678, rd, er, lat, nwr, a1);
        ref_mem[8] = 32'h0BADF00D; ref_mem[9] = 32'h12345678;
        do_req(0, 2'd2, 0, 32'h20, 32'h0, rd, er, lat, nwr, a2);
        do_req(0, 2'd3, 0, 32'h24, 32'h0, rd, er, lat, nwr, a3);
        checks++;
        if (a1 - a0 !== 3 || a3 - a2 !== 4) begin
            errors++; $display("FAIL b2b_spacing store=%0d load=%0d want 3 4", a1 - a0, a3 - a2);
        end
        checks++;
        if (rd !== 32'h12345678) begin
            errors++; $display("FAIL b2b_size3_load rd=%h want 12345678", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp; logic er, w, u; logic [1:0] sz;
        int lat, nwr, acc, idx, exp_lat;
        bit mis;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_req(1, 2'd2, 0, 32'(i) << 2, d, rd, er, lat, nwr, acc);
            ref_mem[i] = d;
        end
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            idx = int'((a >> 2) & 32'hFFF);
            mis = model_mis(sz, a);
            exp_lat = mis ? 0 : (w && sz >= 2'd2) ? 1 : w ? 3 : 2;
            exp = (mis || w) ? 32'd0 : model_load(ref_mem[idx], sz, u, a);
            do_req(w, sz, u, a, d, rd, er, lat, nwr, acc);
            if (w && !mis) ref_mem[idx] = model_store(ref_mem[idx], sz, a, d);
            checks++;
            if (lat !== exp_lat || er !== mis || rd !== exp || nwr !== ((w && !mis) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_%0d w=%b sz=%0d u=%b a=%h got lat=%0d er=%b rd=%h nwr=%0d want lat=%0d er=%b rd=%h",
                         n, w, sz, u, a, lat, er, rd, nwr, exp_lat, mis, exp);
            end
            if (!mis) begin
                checks++;
                if (memory_access_address !== 32'(idx)) begin
                    errors++; $display("FAIL rand_addr_%0d ma=%h want %h", n, memory_access_address, idx);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++; $display("FAIL final_mem_%0d got %h want %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, nwr, acc;
        do_req(1, 2'd2, 0, 32'h10, 32'h11223344, rd, er, lat, nwr, acc);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_address = 32'h10; req_write_data = 32'h55;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (memory_write_enable !== 1'b1) begin
            errors++; $display("FAIL mid_write_state we=%b want 1", memory_write_enable);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (memory_write_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset we=%b rr=%b rv=%b want 0 1 0", memory_write_enable, req_ready, resp_valid);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (mem[4] !== 32'h11223344) begin
            errors++; $display("FAIL mid_reset_mem mem4=%h want 11223344", mem[4]);
        end
        do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, nwr, acc);
        checks++;
        if (rd !== 32'h11223344 || lat !== 2) begin
            errors++; $display("FAIL after_reset_load rd=%h lat=%0d want 11223344 2", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
